// File: rtl/dct8_mem_sched.sv
// dct8_mem_sched: four-stage ping-pong read/write-back scheduler for the memory-based 8-point DCT.
// Optional busy-cycle counter enabled by defining DCT8_SCHED_PERF_EN.
module dct8_mem_sched #(
  parameter int N   = 8,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic [1:0]  stage,
  output logic        rd_en,
  output logic [3:0]  rd_addr,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [15:0] perf_cycles
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  logic [1:0] state_q, state_d, stage_q, stage_d;
  logic [2:0] idx_q, idx_d, cnt_q, cnt_d, perm;
  logic       busy_q, done_q, rd_en_q;
  logic [3:0] rd_addr_q;
  logic [4:0] pipe_q [LAT];
  logic       accept, issue, drain_end;
  // done_q blocks a start seen while done is still showing, so the done cycle never restarts
  assign accept    = state_q == S_IDLE && start && !done_q;
  assign issue     = state_q == S_READ && !hold;
  assign drain_end = state_q == S_DRAIN && cnt_q == 3'(LAT - 1);
  // per-stage butterfly read-index permutation
  always_comb begin
    perm = stage_q == 2'd0 ? idx_q :
           stage_q == 2'd1 ? {idx_q[0], idx_q[2:1]} :
           stage_q == 2'd2 ? {idx_q[1:0], idx_q[2]} :
                             {idx_q[0], idx_q[1], idx_q[2]};
  end
  // stage sequencing: issue eight reads, drain LAT cycles, advance or finish
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_READ;
        stage_d = 2'd0;
        idx_d   = 3'd0;
      end
      S_READ: if (issue) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(N - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = 3'd0;
        end
      end
      S_DRAIN: if (!drain_end) cnt_d = cnt_q + 3'd1;
        else if (stage_q == 2'd3) state_d = S_DONE;
        else begin
          state_d = S_READ;
          stage_d = stage_q + 2'd1;
          idx_d   = 3'd0;
        end
      default: state_d = S_IDLE;
    endcase
  end
  // control state and registered read-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      stage_q   <= 2'd0;
      idx_q     <= 3'd0;
      cnt_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= state_q == S_READ || state_q == S_DRAIN;
      done_q    <= state_q == S_DONE;
      rd_en_q   <= issue;
      rd_addr_q <= issue ? {stage_q[0], perm} : 4'd0;
    end
  end
  // write-back delay line: each issued read returns LAT cycles later to the opposite bank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= 5'd0;
    end else begin
      pipe_q[0] <= rd_en_q ? {1'b1, ~rd_addr_q[3], rd_addr_q[2:0]} : 5'd0;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign stage   = stage_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = pipe_q[LAT-1][4];
  assign wr_addr = pipe_q[LAT-1][3:0];
`ifdef DCT8_SCHED_PERF_EN
  logic [15:0] pc_q, pc_d, perf_q;
  assign pc_d = (busy_q && pc_q != 16'hFFFF) ? pc_q + 16'd1 : pc_q;
  // saturating busy-cycle counter, latched into perf_cycles as the transform finishes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= 16'd0;
      perf_q <= 16'd0;
    end else begin
      pc_q <= accept ? 16'd0 : pc_d;
      if (state_q == S_DONE) perf_q <= pc_d;
    end
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_dct8_mem_sched.sv
// tb_dct8_mem_sched: model-checked bench for dct8_mem_sched at LAT = 2, 1 and 7.
module tb_dct8_mem_sched;
`ifdef DCT8_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
  always #5 clk = ~clk;
  logic        busy_w [3], done_w [3], rd_en_w [3], wr_en_w [3];
  logic [1:0]  stage_w [3];
  logic [3:0]  rd_addr_w [3], wr_addr_w [3];
  logic [15:0] perf_w [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dct8_mem_sched #(.N(8), .LAT(g == 0 ? 2 : (g == 1 ? 1 : 7))) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .busy(busy_w[g]), .done(done_w[g]), .stage(stage_w[g]),
      .rd_en(rd_en_w[g]), .rd_addr(rd_addr_w[g]),
      .wr_en(wr_en_w[g]), .wr_addr(wr_addr_w[g]), .perf_cycles(perf_w[g])
    );
  end
  int total = 0, bad = 0, ecnt = -1;
  bit act [3], pdone [3], seen [3];
  int mn [3], wt [3], bcnt [3], acc [3], rel [3], dcount [3], wrcnt [3];
  logic [4:0]  hist [3][8];
  logic        e_busy [3], e_done [3], e_rd [3], e_wr [3];
  logic [3:0]  e_ra [3], e_wa [3];
  logic [1:0]  e_stg [3];
  logic [15:0] e_perf [3];
  logic [3:0]  lit1 [8] = '{4'h8, 4'hC, 4'h9, 4'hD, 4'hA, 4'hE, 4'hB, 4'hF};

  function automatic int lat_of(int k);
    return k == 0 ? 2 : (k == 1 ? 1 : 7);
  endfunction

  function automatic logic [3:0] addr_of(int n);
    int s, i, p;
    s = n / 8;
    i = n % 8;
    case (s)
      0: p = i;
      1: p = ((i & 1) << 2) | (i >> 1);
      2: p = ((i & 3) << 1) | (i >> 2);
      default: p = ((i & 1) << 2) | (i & 2) | (i >> 2);
    endcase
    return 4'(((s & 1) << 3) | p);
  endfunction

  task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s lat%0d edge %0d: got=%h exp=%h", nm, lat_of(k), ecnt, got, exp);
    end
  endtask

  task automatic model_step();
    ecnt++;
    for (int k = 0; k < 3; k++) begin
      logic r, eb, ed;
      logic [3:0] a;
      int l;
      l = lat_of(k);
      r = 1'b0; eb = 1'b0; ed = 1'b0; a = 4'd0;
      if (!rst_n) begin
        act[k] = 0; mn[k] = 0; wt[k] = 0; pdone[k] = 0;
        e_perf[k] = 16'd0; e_wr[k] = 1'b0; e_wa[k] = 4'd0;
        for (int j = 0; j < 8; j++) hist[k][j] = 5'd0;
      end else begin
        if (!act[k]) begin
          if (start && !pdone[k]) begin
            act[k] = 1; mn[k] = 0; wt[k] = 0; bcnt[k] = 0; acc[k] = ecnt;
          end
        end else if (mn[k] < 32 && wt[k] == 0) begin
          eb = 1'b1;
          if (!hold) begin
            r = 1'b1;
            a = addr_of(mn[k]);
            e_stg[k] = 2'(mn[k] / 8);
            mn[k]++;
            if (mn[k] % 8 == 0) wt[k] = l;
          end
        end else if (wt[k] > 0) begin
          eb = 1'b1;
          wt[k]--;
        end else begin
          ed = 1'b1;
          act[k] = 0;
        end
        bcnt[k] += int'(eb);
        if (ed) e_perf[k] = PERF ? 16'(bcnt[k]) : 16'd0;
        pdone[k] = ed;
        e_wr[k] = hist[k][l-1][4];
        e_wa[k] = hist[k][l-1][3:0];
        for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = r ? {1'b1, ~a[3], a[2:0]} : 5'd0;
      end
      e_busy[k] = eb; e_done[k] = ed; e_rd[k] = r; e_ra[k] = a;
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      chk("busy", k, 16'(busy_w[k]), 16'(e_busy[k]));
      chk("done", k, 16'(done_w[k]), 16'(e_done[k]));
      chk("rd_en", k, 16'(rd_en_w[k]), 16'(e_rd[k]));
      chk("rd_addr", k, 16'(rd_addr_w[k]), 16'(e_ra[k]));
      chk("wr_en", k, 16'(wr_en_w[k]), 16'(e_wr[k]));
      chk("wr_addr", k, 16'(wr_addr_w[k]), 16'(e_wa[k]));
      chk("perf", k, perf_w[k], e_perf[k]);
      if (e_rd[k]) chk("stage", k, 16'(stage_w[k]), 16'(e_stg[k]));
      if (rd_en_w[k] === 1'b1 && wr_en_w[k] === 1'b1)
        chk("bank_clash", k, 16'(rd_addr_w[k][3] ^ wr_addr_w[k][3]), 16'd1);
      if (done_w[k] === 1'b1 && !seen[k]) begin
        seen[k] = 1;
        rel[k] = ecnt - acc[k];
      end
      dcount[k] += int'(done_w[k] === 1'b1);
      wrcnt[k] += int'(wr_en_w[k] === 1'b1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    cmp_all();
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 3; k++) begin
      seen[k] = 0; rel[k] = -1; dcount[k] = 0; wrcnt[k] = 0;
    end
  endtask

  task automatic chk_done_at(input int d0, input int d1, input int d2);
    chk("done_cycle", 0, 16'(rel[0]), 16'(d0));
    chk("done_cycle", 1, 16'(rel[1]), 16'(d1));
    chk("done_cycle", 2, 16'(rel[2]), 16'(d2));
  endtask

  initial begin
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, 16'(busy_w[k]), 16'd0);
      chk("rst_stage", k, 16'(stage_w[k]), 16'd0);
      chk("rst_wr_en", k, 16'(wr_en_w[k]), 16'd0);
      chk("rst_perf", k, perf_w[k], 16'd0);
    end
    rst_n = 1'b1;
    tick();
    // basic run with start pulses while busy and in the done cycle
    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 95; c++) begin
      tick();
      if (c >= 11 && c <= 18) begin
        chk("s1_rd_en", 0, 16'(rd_en_w[0]), 16'd1);
        chk("s1_rd_addr", 0, 16'(rd_addr_w[0]), 16'(lit1[c-11]));
      end
      if (c == 13) begin
        chk("s1_wr_en", 0, 16'(wr_en_w[0]), 16'd1);
        chk("s1_wr_addr", 0, 16'(wr_addr_w[0]), 16'd0);
      end
      if (c == 42) chk("busy_after_done", 0, 16'(busy_w[0]), 16'd0);
      start = (c == 5 || c == 41);
    end
    chk_done_at(41, 37, 61);
    chk("done_count", 0, 16'(dcount[0]), 16'd1);
    chk("done_count", 2, 16'(dcount[2]), 16'd1);
    chk("perf_basic", 0, perf_w[0], PERF ? 16'd40 : 16'd0);
    // hold for three cycles during stage-1 reads at LAT = 2
    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (c >= 13 && c <= 15) chk("hold_rd_en", 0, 16'(rd_en_w[0]), 16'd0);
      if (c == 13 || c == 14) chk("hold_wr_en", 0, 16'(wr_en_w[0]), 16'd1);
      if (c == 16) chk("resume_rd_en", 0, 16'(rd_en_w[0]), 16'd1);
      hold = (c >= 12 && c <= 14);
    end
    chk_done_at(44, 40, 61);
    chk("perf_hold", 0, perf_w[0], PERF ? 16'd43 : 16'd0);
    // reset during stage-2 reads, then a clean run
    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 23; c++) tick();
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_busy", k, 16'(busy_w[k]), 16'd0);
      chk("mid_rst_rd", k, {11'd0, rd_en_w[k], rd_addr_w[k]}, 16'd0);
      chk("mid_rst_wr", k, {11'd0, wr_en_w[k], wr_addr_w[k]}, 16'd0);
      chk("mid_rst_stage", k, 16'(stage_w[k]), 16'd0);
      chk("mid_rst_perf", k, perf_w[k], 16'd0);
    end
    rst_n = 1'b1;
    clear_obs();
    for (int c = 25; c <= 40; c++) tick();
    for (int k = 0; k < 3; k++) chk("wr_after_rst", k, 16'(wrcnt[k]), 16'd0);
    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 70; c++) tick();
    chk_done_at(41, 37, 61);
    chk("perf_clean", 0, perf_w[0], PERF ? 16'd40 : 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
